// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - Shared constants, FSM encoding and helpers for the MMU register port arbiter.
package mmu_pkg;

   localparam int MMU_ADDR_W   = 4;
   localparam int MMU_DATA_W   = 32;
   localparam int MMU_NUM_REGS = 6;

   localparam logic [MMU_ADDR_W-1:0] REG_CRP   = 4'd0;
   localparam logic [MMU_ADDR_W-1:0] REG_SRP   = 4'd1;
   localparam logic [MMU_ADDR_W-1:0] REG_TC    = 4'd2;
   localparam logic [MMU_ADDR_W-1:0] REG_TT0   = 4'd3;
   localparam logic [MMU_ADDR_W-1:0] REG_TT1   = 4'd4;
   localparam logic [MMU_ADDR_W-1:0] REG_MMUSR = 4'd5;

   localparam logic REQ_CPU  = 1'b0;
   localparam logic REQ_WALK = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } arb_state_e;

   function automatic logic idx_illegal(input logic [MMU_ADDR_W-1:0] idx, input int nregs);
      return int'(idx) >= nregs;
   endfunction

endpackage

// File: rtl/mmu_reg_arb_if.sv
// rtl/mmu_reg_arb_if.sv - Requester and register-block signals of the MMU register port arbiter.
// lock0 exists only when MMU_REG_ARB_LOCK_EN is defined.
interface mmu_reg_arb_if
   import mmu_pkg::*;
#(
   parameter int ADDR_W = MMU_ADDR_W,
   parameter int DATA_W = MMU_DATA_W
);
   logic              req0, req1;
   logic              we0, we1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              ack0, ack1;
   logic              err0, err1;
   logic [DATA_W-1:0] rdata0, rdata1;
   logic              reg_wr_en;
   logic              reg_rd_en;
   logic [ADDR_W-1:0] reg_addr;
   logic [DATA_W-1:0] reg_wr_data;
   logic [DATA_W-1:0] reg_rd_data;
   logic              busy;
`ifdef MMU_REG_ARB_LOCK_EN
   logic              lock0;

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, reg_rd_data, lock0,
      input  ack0, ack1, err0, err1, rdata0, rdata1,
      input  reg_wr_en, reg_rd_en, reg_addr, reg_wr_data, busy
   );

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, reg_rd_data, lock0,
      output ack0, ack1, err0, err1, rdata0, rdata1,
      output reg_wr_en, reg_rd_en, reg_addr, reg_wr_data, busy
   );
`else
   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, reg_rd_data,
      input  ack0, ack1, err0, err1, rdata0, rdata1,
      input  reg_wr_en, reg_rd_en, reg_addr, reg_wr_data, busy
   );

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, reg_rd_data,
      output ack0, ack1, err0, err1, rdata0, rdata1,
      output reg_wr_en, reg_rd_en, reg_addr, reg_wr_data, busy
   );
`endif
endinterface

// File: rtl/mmu_rr_arb2.sv
// rtl/mmu_rr_arb2.sv - Two-way round-robin picker; ptr_q names the port favoured on the next collision.
module mmu_rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   input  logic       update_i,
   output logic [1:0] gnt_o
);
   logic ptr_q, ptr_d;

   always_comb begin
      gnt_o = req_i;
      if (&req_i) begin
         gnt_o = ptr_q ? 2'b10 : 2'b01;
      end
   end

   // After a grant the other port becomes favoured: winner 0 -> ptr 1, winner 1 -> ptr 0.
   always_comb begin
      ptr_d = ptr_q;
      if (update_i && |gnt_o) begin
         ptr_d = gnt_o[0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/mmu_reg_arb.sv
// rtl/mmu_reg_arb.sv - MMU register port arbiter: round-robin grant, then latch/issue/respond.
// Defining MMU_REG_ARB_LOCK_EN adds lock0 so port 0 can hold the port for read-modify-write.
module mmu_reg_arb
   import mmu_pkg::*;
#(
   parameter int ADDR_W   = MMU_ADDR_W,
   parameter int DATA_W   = MMU_DATA_W,
   parameter int NUM_REGS = MMU_NUM_REGS
) (
   input  logic         clk,
   input  logic         rst_n,
   mmu_reg_arb_if.slave bus
);
   arb_state_e        state_q, state_d;
   logic              gid_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              ill_q;
   logic [DATA_W-1:0] resp_q;

   logic [1:0]        elig;
   logic [1:0]        gnt;
   logic              arb_upd;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

`ifdef MMU_REG_ARB_LOCK_EN
   logic lock_q;

   // Lock state is refreshed each time a port-0 access finishes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_q <= 1'b0;
      end else if (state_q == ST_RESP && gid_q == REQ_CPU) begin
         lock_q <= bus.lock0;
      end
   end

   assign elig    = {bus.req1 & ~lock_q, bus.req0};
   assign arb_upd = (state_q == ST_IDLE) & ~lock_q;
`else
   assign elig    = {bus.req1, bus.req0};
   assign arb_upd = (state_q == ST_IDLE);
`endif

   mmu_rr_arb2 u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_i    (state_q == ST_IDLE ? elig : 2'b00),
      .update_i (arb_upd),
      .gnt_o    (gnt)
   );

   assign sel_we    = gnt[1] ? bus.we1    : bus.we0;
   assign sel_addr  = gnt[1] ? bus.addr1  : bus.addr0;
   assign sel_wdata = gnt[1] ? bus.wdata1 : bus.wdata0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (|gnt) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_RESP;
         ST_RESP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gid_q   <= REQ_CPU;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         ill_q   <= 1'b0;
         resp_q  <= '0;
      end else begin
         if (state_q == ST_IDLE && |gnt) begin
            gid_q   <= gnt[1] ? REQ_WALK : REQ_CPU;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            ill_q   <= idx_illegal(sel_addr, NUM_REGS);
         end
         // Only legal reads return register data; writes and rejected indices answer zero.
         if (state_q == ST_ISSUE) begin
            resp_q <= (!we_q && !ill_q) ? bus.reg_rd_data : '0;
         end
      end
   end

   always_comb begin
      bus.reg_wr_en   = 1'b0;
      bus.reg_rd_en   = 1'b0;
      bus.reg_addr    = '0;
      bus.reg_wr_data = '0;
      bus.ack0        = 1'b0;
      bus.err0        = 1'b0;
      bus.rdata0      = '0;
      bus.ack1        = 1'b0;
      bus.err1        = 1'b0;
      bus.rdata1      = '0;
      bus.busy        = (state_q != ST_IDLE);
      unique case (state_q)
         ST_ISSUE: begin
            bus.reg_addr    = addr_q;
            bus.reg_wr_data = wdata_q;
            bus.reg_wr_en   = we_q & ~ill_q;
            bus.reg_rd_en   = ~we_q & ~ill_q;
         end
         ST_RESP: begin
            if (gid_q == REQ_WALK) begin
               bus.ack1   = 1'b1;
               bus.err1   = ill_q;
               bus.rdata1 = resp_q;
            end else begin
               bus.ack0   = 1'b1;
               bus.err0   = ill_q;
               bus.rdata0 = resp_q;
            end
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_mmu_reg_arb.sv
// tb/tb_mmu_reg_arb.sv - Directed and randomized checks of mmu_reg_arb against a transaction-level model.
module tb_mmu_reg_arb;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   mmu_reg_arb_if #(.ADDR_W(4), .DATA_W(32)) bus ();

   mmu_reg_arb dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: one access in flight; age 0 = none, 1 = on the register bus, 2 = answering.
   int          m_age;
   int          m_port;
   bit          m_we;
   logic [3:0]  m_addr;
   logic [31:0] m_wdata;
   bit          m_ill;
   logic [31:0] m_rd;
   int          m_fav;
   bit          m_locked;

   always @(posedge clk or negedge rst_n) begin : model
      int  w;
      bit  c0, c1;
      if (!rst_n) begin
         m_age <= 0; m_port <= 0; m_we <= 0; m_addr <= 0; m_wdata <= 0;
         m_ill <= 0; m_rd <= 0; m_fav <= 0; m_locked <= 0;
      end else if (m_age == 0) begin
         c0 = bus.req0;
         c1 = bus.req1 && !m_locked;
         if (c0 || c1) begin
            w = (c0 && c1) ? m_fav : (c1 ? 1 : 0);
            if (!m_locked) m_fav <= 1 - w;
            m_port  <= w;
            m_we    <= (w == 1) ? bus.we1 : bus.we0;
            m_addr  <= (w == 1) ? bus.addr1 : bus.addr0;
            m_wdata <= (w == 1) ? bus.wdata1 : bus.wdata0;
            m_ill   <= int'((w == 1) ? bus.addr1 : bus.addr0) >= 6;
            m_age   <= 1;
         end
      end else if (m_age == 1) begin
         m_rd  <= (!m_we && !m_ill) ? bus.reg_rd_data : 32'h0;
         m_age <= 2;
      end else begin
`ifdef MMU_REG_ARB_LOCK_EN
         if (m_port == 0) m_locked <= bus.lock0;
`endif
         m_age <= 0;
      end
   end

   task automatic chk1(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_check();
      bit iss, rsp, a0, a1;
      iss = (m_age == 1);
      rsp = (m_age == 2);
      a0  = rsp && m_port == 0;
      a1  = rsp && m_port == 1;
      chk1 ("m_busy",   bus.busy,      m_age != 0);
      chk1 ("m_wr_en",  bus.reg_wr_en, iss && m_we && !m_ill);
      chk1 ("m_rd_en",  bus.reg_rd_en, iss && !m_we && !m_ill);
      chk32("m_addr",   {28'd0, bus.reg_addr}, iss ? {28'd0, m_addr} : 32'h0);
      chk32("m_wdata",  bus.reg_wr_data, iss ? m_wdata : 32'h0);
      chk1 ("m_ack0",   bus.ack0, a0);
      chk1 ("m_err0",   bus.err0, a0 && m_ill);
      chk32("m_rdata0", bus.rdata0, a0 ? m_rd : 32'h0);
      chk1 ("m_ack1",   bus.ack1, a1);
      chk1 ("m_err1",   bus.err1, a1 && m_ill);
      chk32("m_rdata1", bus.rdata1, a1 ? m_rd : 32'h0);
   endtask

   task automatic look();
      @(negedge clk);
      model_check();
   endtask

   task automatic adv();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      rst_n = 1'b0;
      look();
      chk1("rst_busy", bus.busy, 1'b0);
      chk1("rst_ack0", bus.ack0, 1'b0);
      chk1("rst_wren", bus.reg_wr_en, 1'b0);
      adv();
      rst_n = 1'b1;
   endtask

   bit pend0, pend1, seen0, seen1;

   initial begin
      total = 0; bad = 0;
      rst_n = 1'b0;
      bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
      bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
      bus.reg_rd_data = 0;
`ifdef MMU_REG_ARB_LOCK_EN
      bus.lock0 = 0;
`endif
      adv();
      do_reset();

      // Port 0 writes TC.
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 4'd2; bus.wdata0 = 32'h8000_C000;
      bus.reg_rd_data = 32'hDEAD_BEEF;
      look(); chk1("t1_busy0", bus.busy, 1'b0); adv();
      look(); chk1("t1_wr_en", bus.reg_wr_en, 1'b1); chk32("t1_addr", {28'd0, bus.reg_addr}, 32'd2);
      chk32("t1_wdata", bus.reg_wr_data, 32'h8000_C000); chk1("t1_busy1", bus.busy, 1'b1); adv();
      look(); chk1("t1_ack0", bus.ack0, 1'b1); chk1("t1_err0", bus.err0, 1'b0);
      chk1("t1_busy2", bus.busy, 1'b1); adv();
      bus.req0 = 0;
      look(); chk1("t1_idle", bus.busy, 1'b0); adv();

      // Port 1 reads CRP.
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 4'd0; bus.reg_rd_data = 32'h0012_3400;
      look(); adv();
      look(); chk1("t2_rd_en", bus.reg_rd_en, 1'b1); chk1("t2_wr_en", bus.reg_wr_en, 1'b0); adv();
      look(); chk1("t2_ack1", bus.ack1, 1'b1); chk32("t2_rdata1", bus.rdata1, 32'h0012_3400);
      chk1("t2_ack0", bus.ack0, 1'b0); adv();
      bus.req1 = 0;
      look(); adv();

      // Simultaneous requests from reset alternate starting with port 0.
      do_reset();
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 4'd1;
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 4'd3; bus.reg_rd_data = 32'h0000_5A5A;
      look(); adv(); look(); adv();
      look(); chk1("t3_c2_ack0", bus.ack0, 1'b1); chk1("t3_c2_ack1", bus.ack1, 1'b0); adv();
      bus.req0 = 0;
      look(); adv(); look(); adv();
      look(); chk1("t3_c5_ack1", bus.ack1, 1'b1); chk32("t3_c5_rd1", bus.rdata1, 32'h0000_5A5A); adv();
      bus.req1 = 0;
      look(); adv();
      bus.req0 = 1; bus.req1 = 1;
      look(); adv(); look(); adv();
      look(); chk1("t3_c9_ack0", bus.ack0, 1'b1); chk1("t3_c9_ack1", bus.ack1, 1'b0); adv();
      bus.req0 = 0;
      look(); adv(); look(); adv();
      look(); chk1("t3_c12_ack1", bus.ack1, 1'b1); adv();
      bus.req1 = 0;
      look(); adv();

      // Illegal index read from port 0.
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 4'd7; bus.reg_rd_data = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         look();
         chk1("t4_no_en", bus.reg_rd_en | bus.reg_wr_en, 1'b0);
         if (i == 2) begin
            chk1("t4_ack0", bus.ack0, 1'b1); chk1("t4_err0", bus.err0, 1'b1);
            chk32("t4_rdata0", bus.rdata0, 32'h0);
         end
         adv();
      end
      bus.req0 = 0;
      look(); adv();

      // Reset asserted during ISSUE aborts the access.
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 4'd4; bus.reg_rd_data = 32'h0000_0044;
      look(); adv();
      #1 rst_n = 1'b0;
      #1;
      chk1("t5_busy", bus.busy, 1'b0); chk1("t5_rd_en", bus.reg_rd_en, 1'b0);
      chk32("t5_addr", {28'd0, bus.reg_addr}, 32'h0);
      look(); adv();
      look(); chk1("t5_no_ack", bus.ack1, 1'b0); adv();
      rst_n = 1'b1;
      look(); adv();
      look(); chk1("t5_rd_en2", bus.reg_rd_en, 1'b1); chk32("t5_addr2", {28'd0, bus.reg_addr}, 32'd4); adv();
      look(); chk1("t5_ack1", bus.ack1, 1'b1); chk32("t5_rdata1", bus.rdata1, 32'h0000_0044); adv();
      bus.req1 = 0;
      look(); adv();

`ifdef MMU_REG_ARB_LOCK_EN
      // Locked read-modify-write of MMUSR from port 0 with port 1 pending.
      do_reset();
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 4'd5; bus.lock0 = 1;
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 4'd1; bus.reg_rd_data = 32'h0000_00A5;
      look(); adv(); look(); adv();
      look(); chk1("lk_ack0a", bus.ack0, 1'b1); chk1("lk_ack1a", bus.ack1, 1'b0); adv();
      bus.req0 = 0;
      look(); chk1("lk_held", bus.busy, 1'b0); adv();
      bus.req0 = 1; bus.we0 = 1; bus.wdata0 = 32'h0000_0F0F; bus.lock0 = 0;
      look(); adv();
      look(); chk1("lk_wr_en", bus.reg_wr_en, 1'b1); adv();
      look(); chk1("lk_ack0b", bus.ack0, 1'b1); chk1("lk_ack1b", bus.ack1, 1'b0); adv();
      bus.req0 = 0;
      look(); adv();
      look(); chk1("lk_rd_en1", bus.reg_rd_en, 1'b1); adv();
      look(); chk1("lk_ack1c", bus.ack1, 1'b1); chk32("lk_rdata1", bus.rdata1, 32'h0000_00A5); adv();
      bus.req1 = 0;
      look(); adv();
`endif

      // Randomized traffic from both requesters.
      pend0 = 0; pend1 = 0; seen0 = 0; seen1 = 0;
      for (int c = 0; c < 3000; c++) begin
         bus.reg_rd_data = $urandom;
         if (pend0 && seen0) begin
            bus.req0 = 0; pend0 = 0;
         end else if (!pend0 && $urandom_range(0, 2) == 0) begin
            bus.req0 = 1; pend0 = 1;
            bus.we0 = 1'($urandom_range(0, 1));
            bus.addr0 = 4'($urandom_range(0, 7));
            bus.wdata0 = $urandom;
`ifdef MMU_REG_ARB_LOCK_EN
            bus.lock0 = ($urandom_range(0, 3) == 0);
`endif
         end
         if (pend1 && seen1) begin
            bus.req1 = 0; pend1 = 0;
         end else if (!pend1 && $urandom_range(0, 2) == 0) begin
            bus.req1 = 1; pend1 = 1;
            bus.we1 = 1'($urandom_range(0, 1));
            bus.addr1 = 4'($urandom_range(0, 7));
            bus.wdata1 = $urandom;
         end
         look();
         seen0 = bus.ack0;
         seen1 = bus.ack1;
         adv();
      end
      bus.req0 = 0; bus.req1 = 0;
      for (int i = 0; i < 4; i++) begin
         look(); adv();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
